// File: rtl/stt_pkg.sv
// Shared types and sizing for the STT untaint issue scheduler.
// A YRoT is a ROB index plus a wrap bit in the MSB.
package stt_pkg;

    localparam int YROT_WIDTH  = 9;
    localparam int NUM_ENTRIES = 8;
    localparam int TAG_WIDTH   = 6;
    localparam int IDX_WIDTH   = $clog2(NUM_ENTRIES);
    localparam int OCC_WIDTH   = $clog2(NUM_ENTRIES + 1);

    typedef logic [YROT_WIDTH:0] yrot_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        yrot_t                yrot;
    } sched_entry_t;

    function automatic logic [OCC_WIDTH-1:0] count_valid(input logic [NUM_ENTRIES-1:0] v);
        logic [OCC_WIDTH-1:0] n;
        n = {OCC_WIDTH{1'b0}};
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            n = n + {{(OCC_WIDTH-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/untaint_issue_sched_oldest_pick.sv
// Tournament tree selecting the oldest eligible slot; ties resolve to the lower index.
// Leaves are padded to a power of two with ineligible entries.
module oldest_pick
    import stt_pkg::*;
#(
    parameter int N  = NUM_ENTRIES,
    parameter int IW = $clog2(N)
)
(
    input  logic [N-1:0]  elig,
    input  yrot_t         yrot [N],
    input  logic          wrap_bit,
    output logic          found,
    output logic [IW-1:0] idx
);

    localparam int P = 1 << IW;

    logic          node_valid [2*P-1];
    yrot_t         node_yrot  [2*P-1];
    logic [IW-1:0] node_idx   [2*P-1];

    genvar j;
    generate
        for (j = 0; j < P; j++) begin : g_leaf
            if (j < N) begin : g_real
                assign node_valid[P-1+j] = elig[j];
                assign node_yrot[P-1+j]  = yrot[j];
            end else begin : g_pad
                assign node_valid[P-1+j] = 1'b0;
                assign node_yrot[P-1+j]  = '0;
            end
            assign node_idx[P-1+j] = IW'(j);
        end

        // Right child wins only when strictly older, or the left child is not eligible.
        for (j = 0; j < P-1; j++) begin : g_node
            logic r_older;
            logic take_r;
            younger_than u_cmp (
                .yrot1    (node_yrot[2*j+2]),
                .yrot2    (node_yrot[2*j+1]),
                .wrap_bit (wrap_bit),
                .result   (r_older)
            );
            assign take_r        = node_valid[2*j+2] & (~node_valid[2*j+1] | r_older);
            assign node_valid[j] = node_valid[2*j+1] | node_valid[2*j+2];
            assign node_yrot[j]  = take_r ? node_yrot[2*j+2] : node_yrot[2*j+1];
            assign node_idx[j]   = take_r ? node_idx[2*j+2]  : node_idx[2*j+1];
        end
    endgenerate

    assign found = node_valid[0];
    assign idx   = node_idx[0];

endmodule

// File: rtl/younger_than.sv
// Age comparator: result=1 when yrot1 is strictly older than yrot2.
// When the wrap bits differ, the entry whose wrap bit differs from the current ROB wrap bit is from the previous lap.
module younger_than
    import stt_pkg::*;
(
    input  yrot_t yrot1,
    input  yrot_t yrot2,
    input  logic  wrap_bit,
    output logic  result
);

    // Same lap compares indices; different laps are resolved by the current wrap bit.
    always_comb begin
        if (yrot1[YROT_WIDTH] == yrot2[YROT_WIDTH]) begin
            result = (yrot1[YROT_WIDTH-1:0] < yrot2[YROT_WIDTH-1:0]);
        end else begin
            result = wrap_bit ? yrot2[YROT_WIDTH] : yrot1[YROT_WIDTH];
        end
    end

endmodule

// File: rtl/untaint_issue_sched.sv
// Buffer of taint-blocked ops; grants the oldest op whose YRoT is older than the
// visibility point into a one-deep output register and squashes on mispredict.
module untaint_issue_sched
    import stt_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrap_bit,
    input  yrot_t                vp_yrot,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  yrot_t                in_yrot,
    input  logic                 squash_valid,
    input  yrot_t                squash_yrot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_WIDTH-1:0] out_tag,
    output yrot_t                out_yrot,
    output logic [OCC_WIDTH-1:0] occupancy
);

    sched_entry_t             slot_r    [NUM_ENTRIES];
    sched_entry_t             slot_next [NUM_ENTRIES];
    yrot_t                    slot_yrot [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]   elig_s;
    logic [NUM_ENTRIES-1:0]   vp_older_s;
    logic [NUM_ENTRIES-1:0]   sq_older_s;
    logic [NUM_ENTRIES-1:0]   valid_next_s;
    logic                     pick_found_s;
    logic [IDX_WIDTH-1:0]     pick_idx_s;
    logic                     free_found_s;
    logic [IDX_WIDTH-1:0]     free_idx_s;
    logic                     in_older_sq_s;
    logic                     out_older_sq_s;
    logic                     load_s;
    logic                     alloc_s;
    logic                     out_valid_next;
    logic [TAG_WIDTH-1:0]     out_tag_next;
    yrot_t                    out_yrot_next;

    genvar i;
    generate
        for (i = 0; i < NUM_ENTRIES; i++) begin : g_slot
            younger_than u_vp (
                .yrot1    (slot_r[i].yrot),
                .yrot2    (vp_yrot),
                .wrap_bit (wrap_bit),
                .result   (vp_older_s[i])
            );
            younger_than u_sq (
                .yrot1    (slot_r[i].yrot),
                .yrot2    (squash_yrot),
                .wrap_bit (wrap_bit),
                .result   (sq_older_s[i])
            );
            assign elig_s[i]       = slot_r[i].valid & vp_older_s[i];
            assign slot_yrot[i]    = slot_r[i].yrot;
            assign valid_next_s[i] = slot_next[i].valid;
        end
    endgenerate

    younger_than u_in_sq (
        .yrot1    (in_yrot),
        .yrot2    (squash_yrot),
        .wrap_bit (wrap_bit),
        .result   (in_older_sq_s)
    );

    younger_than u_out_sq (
        .yrot1    (out_yrot),
        .yrot2    (squash_yrot),
        .wrap_bit (wrap_bit),
        .result   (out_older_sq_s)
    );

    oldest_pick #(.N(NUM_ENTRIES), .IW(IDX_WIDTH)) u_pick (
        .elig     (elig_s),
        .yrot     (slot_yrot),
        .wrap_bit (wrap_bit),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    // Lowest-index free slot; scanned downward so the lowest index wins.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {IDX_WIDTH{1'b0}};
        for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
            if (!slot_r[k].valid) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_WIDTH'(k);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    assign load_s  = pick_found_s & (~out_valid | out_ready) & ~squash_valid;
    assign alloc_s = in_valid & in_ready & free_found_s & (~squash_valid | in_older_sq_s);

    // Slot update: the alloc target is always an empty slot, so it never collides with grant or squash.
    always_comb begin
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            slot_next[k] = slot_r[k];
            if (alloc_s && (free_idx_s == IDX_WIDTH'(k))) begin
                slot_next[k].valid = 1'b1;
                slot_next[k].tag   = in_tag;
                slot_next[k].yrot  = in_yrot;
            end else if ((squash_valid && !sq_older_s[k]) ||
                         (load_s && (pick_idx_s == IDX_WIDTH'(k)))) begin
                slot_next[k].valid = 1'b0;
            end else begin
                slot_next[k] = slot_r[k];
            end
        end
    end

    // Output register: a completed handshake takes priority over a squash of the held op.
    always_comb begin
        out_valid_next = out_valid;
        out_tag_next   = out_tag;
        out_yrot_next  = out_yrot;
        if (load_s) begin
            out_valid_next = 1'b1;
            out_tag_next   = slot_r[pick_idx_s].tag;
            out_yrot_next  = slot_r[pick_idx_s].yrot;
        end else if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
        end else if (squash_valid && out_valid && !out_older_sq_s) begin
            out_valid_next = 1'b0;
        end else begin
            out_valid_next = out_valid;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                slot_r[k] <= '0;
            end
            out_valid <= 1'b0;
            out_tag   <= {TAG_WIDTH{1'b0}};
            out_yrot  <= '0;
            occupancy <= {OCC_WIDTH{1'b0}};
            in_ready  <= 1'b1;
        end else begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                slot_r[k] <= slot_next[k];
            end
            out_valid <= out_valid_next;
            out_tag   <= out_tag_next;
            out_yrot  <= out_yrot_next;
            occupancy <= count_valid(valid_next_s);
            in_ready  <= (count_valid(valid_next_s) != OCC_WIDTH'(NUM_ENTRIES));
        end
    end

endmodule

// File: tb/tb_untaint_issue_sched.sv
// Self-checking bench: directed scenarios plus random traffic against an
// age-key reference model of the scheduler.
module tb_untaint_issue_sched;

    logic       clk;
    logic       rst;
    logic       wrap_bit;
    logic [9:0] vp_yrot;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_tag;
    logic [9:0] in_yrot;
    logic       squash_valid;
    logic [9:0] squash_yrot;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_tag;
    logic [9:0] out_yrot;
    logic [3:0] occupancy;

    int checks;
    int errors;

    // reference model state
    bit       m_v [8];
    bit [5:0] m_t [8];
    bit [9:0] m_y [8];
    bit       m_ov;
    bit [5:0] m_ot;
    bit [9:0] m_oy;

    untaint_issue_sched dut (
        .clk          (clk),
        .reset        (rst),
        .wrap_bit     (wrap_bit),
        .vp_yrot      (vp_yrot),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .in_yrot      (in_yrot),
        .squash_valid (squash_valid),
        .squash_yrot  (squash_yrot),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .out_yrot     (out_yrot),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Age as a single number: entries from the previous lap sort before the current lap.
    function automatic int age(input bit [9:0] y, input bit w);
        int lap;
        lap = (y[9] == w) ? 1024 : 0;
        return lap + int'(y[8:0]);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int k = 0; k < 8; k++) n += m_v[k] ? 1 : 0;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("out_tag",   {26'd0, out_tag},   {26'd0, m_ot});
        chk("out_yrot",  {22'd0, out_yrot},  {22'd0, m_oy});
        chk("occupancy", {28'd0, occupancy}, 32'(m_count()));
        chk("in_ready",  {31'd0, in_ready},  {31'd0, (m_count() != 8)});
    endtask

    // One clock: model predicts from pre-edge inputs, DUT sampled 1ns after the edge.
    task automatic tick();
        int  sel, fr, occ;
        bit  load, wr;
        bit       n_v [8];
        bit [5:0] n_t [8];
        bit [9:0] n_y [8];
        bit       n_ov;
        sel = -1;
        for (int k = 0; k < 8; k++) begin
            if (m_v[k] && age(m_y[k], wrap_bit) < age(vp_yrot, wrap_bit)) begin
                if (sel < 0 || age(m_y[k], wrap_bit) < age(m_y[sel], wrap_bit)) sel = k;
            end
        end
        load = (sel >= 0) && (!m_ov || out_ready) && !squash_valid;
        occ  = m_count();
        fr   = -1;
        for (int k = 7; k >= 0; k--) if (!m_v[k]) fr = k;
        wr = in_valid && (occ != 8) &&
             (!squash_valid || age(in_yrot, wrap_bit) < age(squash_yrot, wrap_bit));
        n_v = m_v; n_t = m_t; n_y = m_y; n_ov = m_ov;
        if (squash_valid) begin
            for (int k = 0; k < 8; k++)
                if (!(age(m_y[k], wrap_bit) < age(squash_yrot, wrap_bit))) n_v[k] = 1'b0;
        end
        if (load) begin
            n_v[sel] = 1'b0;
            n_ov = 1'b1;
        end else if (m_ov && out_ready) begin
            n_ov = 1'b0;
        end else if (squash_valid && m_ov && !(age(m_oy, wrap_bit) < age(squash_yrot, wrap_bit))) begin
            n_ov = 1'b0;
        end
        if (wr) begin
            n_v[fr] = 1'b1; n_t[fr] = in_tag; n_y[fr] = in_yrot;
        end
        @(posedge clk);
        #1;
        if (load) begin
            m_ot = m_t[sel];
            m_oy = m_y[sel];
        end
        m_v = n_v; m_t = n_t; m_y = n_y; m_ov = n_ov;
        check_all();
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_v[k] = 1'b0; m_t[k] = 6'd0; m_y[k] = 10'd0;
        end
        m_ov = 1'b0; m_ot = 6'd0; m_oy = 10'd0;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_tag = 6'd0; in_yrot = 10'd0;
        squash_valid = 1'b0; squash_yrot = 10'd0;
        vp_yrot = 10'd0; wrap_bit = 1'b0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_clear();
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occupancy", {28'd0, occupancy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [9:0] y, input logic [5:0] t);
        in_valid = 1'b1; in_yrot = y; in_tag = t;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        model_clear();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: grant order by age, first grant two edges after the 0x003 alloc
        do_reset();
        out_ready = 1'b1;
        alloc(10'h005, 6'd1);
        alloc(10'h003, 6'd2);
        alloc(10'h007, 6'd3);
        vp_yrot = 10'h010;
        chk("t1_no_early", {31'd0, out_valid}, 32'd0);
        tick(); chk("t1_g0", {22'd0, out_yrot}, 32'h003); chk("t1_v0", {31'd0, out_valid}, 32'd1);
        tick(); chk("t1_g1", {22'd0, out_yrot}, 32'h005);
        tick(); chk("t1_g2", {22'd0, out_yrot}, 32'h007); chk("t1_tag2", {26'd0, out_tag}, 32'd3);
        tick(); chk("t1_empty", {31'd0, out_valid}, 32'd0);

        // 2: visibility point gating, equal YRoT is not older
        do_reset();
        out_ready = 1'b1;
        vp_yrot = 10'h010;
        alloc(10'h020, 6'd9);
        tick(); tick();
        chk("t2_blocked", {31'd0, out_valid}, 32'd0);
        vp_yrot = 10'h020;
        tick(); tick();
        chk("t2_equal_vp", {31'd0, out_valid}, 32'd0);
        vp_yrot = 10'h021;
        tick();
        chk("t2_grant", {22'd0, out_yrot}, 32'h020);
        chk("t2_valid", {31'd0, out_valid}, 32'd1);

        // 3: full buffer backpressure
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) alloc(10'(k + 1), 6'(k));
        chk("t3_full_occ", {28'd0, occupancy}, 32'd8);
        chk("t3_full_rdy", {31'd0, in_ready}, 32'd0);
        vp_yrot = 10'h100;
        tick();
        chk("t3_rdy_back", {31'd0, in_ready}, 32'd1);
        chk("t3_first", {22'd0, out_yrot}, 32'h001);

        // 4: wrapped ordering
        do_reset();
        wrap_bit = 1'b1;
        out_ready = 1'b1;
        alloc(10'h202, 6'd1);
        alloc(10'h1FE, 6'd2);
        alloc(10'h1F0, 6'd3);
        tick();
        chk("t4_blocked", {31'd0, out_valid}, 32'd0);
        vp_yrot = 10'h205;
        tick(); chk("t4_g0", {22'd0, out_yrot}, 32'h1F0);
        tick(); chk("t4_g1", {22'd0, out_yrot}, 32'h1FE);
        tick(); chk("t4_g2", {22'd0, out_yrot}, 32'h202);

        // 5: squash with held output, without and with a same-cycle transfer
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            alloc(10'h00A, 6'd7);
            vp_yrot = 10'h00B;
            tick();
            chk("t5_held", {22'd0, out_yrot}, 32'h00A);
            vp_yrot = 10'h000;
            alloc(10'h004, 6'd1);
            alloc(10'h008, 6'd2);
            alloc(10'h00C, 6'd3);
            chk("t5_pre_occ", {28'd0, occupancy}, 32'd3);
            squash_valid = 1'b1;
            squash_yrot = 10'h008;
            out_ready = (pass == 1);
            chk("t5_xfer_valid", {31'd0, out_valid}, 32'd1);
            tick();
            squash_valid = 1'b0;
            out_ready = 1'b1;
            chk("t5_occ", {28'd0, occupancy}, 32'd1);
            chk("t5_out_clr", {31'd0, out_valid}, 32'd0);
            vp_yrot = 10'h010;
            tick();
            chk("t5_survivor", {22'd0, out_yrot}, 32'h004);
        end

        // 6: asynchronous reset mid-cycle while allocating and squashing
        do_reset();
        out_ready = 1'b0;
        alloc(10'h003, 6'd5);
        vp_yrot = 10'h010;
        tick();
        in_valid = 1'b1; in_yrot = 10'h001; in_tag = 6'd4;
        squash_valid = 1'b1; squash_yrot = 10'h002;
        #3;
        rst = 1'b1;
        #1;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_tag", {26'd0, out_tag}, 32'd0);
        chk("t6_yrot", {22'd0, out_yrot}, 32'd0);
        chk("t6_occ", {28'd0, occupancy}, 32'd0);
        model_clear();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("t6_ready", {31'd0, in_ready}, 32'd1);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            in_valid     = ($urandom_range(0, 2) != 0);
            in_yrot      = 10'($urandom);
            in_tag       = 6'($urandom);
            vp_yrot      = 10'($urandom);
            out_ready    = ($urandom_range(0, 3) != 0);
            squash_valid = ($urandom_range(0, 11) == 0);
            squash_yrot  = 10'($urandom);
            if ($urandom_range(0, 63) == 0) wrap_bit = ~wrap_bit;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
